// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default TX FIFO depth and the
// encoding of the transmit drain state machine.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int TX_FIFO_DEPTH = 16;

  // Drain FSM states: wait for data and thre, pulse the core, then hold off.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH  = 2'd1,
    ST_GUARD = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the CPU-side write port, the UART core handshake and the
// status flags of the transmit FIFO.
interface uart_tx_fifo_if #(parameter int AW = 4);
  import uart_pkg::*;

  logic                   wr;
  logic [UART_DATA_W-1:0] din;
  logic                   clr;
  logic                   thre;
  logic                   core_wr;
  logic [UART_DATA_W-1:0] core_d;
  logic                   full;
  logic                   empty;
  logic [AW:0]            level;
  logic                   ovf;
  logic                   irq_lw;

  // Environment side: CPU store path plus the UART core status.
  modport master (
    output wr, din, clr, thre,
    input  core_wr, core_d, full, empty, level, ovf, irq_lw
  );

  // FIFO side.
  modport slave (
    input  wr, din, clr, thre,
    output core_wr, core_d, full, empty, level, ovf, irq_lw
  );

endinterface

// File: rtl/sync_fifo_core.sv
// Generic synchronous FIFO storage: register array, wrapping pointers and
// an explicit occupancy counter. Read data is registered on pop.
module sync_fifo_core #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic [W-1:0]  rd_data_reg;
  logic          do_push, do_pop;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = pop && !clr && (level_reg != '0);
  assign do_push = push && !clr && ((level_reg != DEPTH_L) || do_pop);

  // Occupancy bookkeeping independent of the pointers.
  always_comb begin
    level_next = level_reg;
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Storage write port; no reset so the array maps onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr_reg] <= din;
  end

  // Pointers, level and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else if (clr) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop) begin
        rptr_reg    <= rptr_reg + 1'b1;
        rd_data_reg <= mem[rptr_reg];
      end
      level_reg <= level_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = level_reg;
  assign full    = (level_reg == DEPTH_L);
  assign empty   = (level_reg == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers CPU writes and drains them into the UART core
// one byte per thre, with a guard interval covering the core's thre latency.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = TX_FIFO_DEPTH,
  parameter int AW     = 4,
  parameter int LOW_WM = 4,
  parameter int GUARD  = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [AW:0] LOW_WM_L   = LOW_WM[AW:0];
  localparam logic [2:0]  GUARD_INIT = 3'(GUARD - 1);

  tx_state_t              state_reg, state_next;
  logic [2:0]             guard_reg, guard_next;
  logic                   core_wr_reg, core_wr_next;
  logic                   ovf_reg, ovf_next;
  logic                   pop;
  logic                   fifo_full, fifo_empty;
  logic [AW:0]            fifo_level;
  logic [UART_DATA_W-1:0] fifo_rd_data;

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_DATA_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.wr),
    .pop     (pop),
    .clr     (bus.clr),
    .din     (bus.din),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Drain FSM next state, pop request and core write pulse.
  always_comb begin
    state_next   = state_reg;
    guard_next   = guard_reg;
    core_wr_next = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && bus.thre) begin
          pop          = 1'b1;
          core_wr_next = 1'b1;
          state_next   = ST_PUSH;
        end
      end
      ST_PUSH: begin
        guard_next = GUARD_INIT;
        state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_reg == 3'd0) state_next = ST_IDLE;
        else                   guard_next = guard_reg - 3'd1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (bus.clr) begin
      state_next   = ST_IDLE;
      guard_next   = 3'd0;
      core_wr_next = 1'b0;
      pop          = 1'b0;
    end
  end

  // Sticky overflow: a write dropped because no slot was free this edge.
  always_comb begin
    ovf_next = ovf_reg | (bus.wr && fifo_full && !pop);
    if (bus.clr) ovf_next = 1'b0;
  end

  // FSM, pulse and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      guard_reg   <= 3'd0;
      core_wr_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      guard_reg   <= guard_next;
      core_wr_reg <= core_wr_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign bus.core_wr = core_wr_reg;
  assign bus.core_d  = fifo_rd_data;
  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;
  assign bus.level   = fifo_level;
  assign bus.ovf     = ovf_reg;
  assign bus.irq_lw  = (fifo_level <= LOW_WM_L);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH_C = 16;
  localparam int LOW_C   = 4;
  localparam int GUARD_C = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.AW(4)) bus();

  uart_tx_fifo #(.DEPTH(DEPTH_C), .AW(4), .LOW_WM(LOW_C), .GUARD(GUARD_C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: byte queue plus earliest edge at which the next pop may happen.
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_core_wr;
  logic [7:0] m_core_d;
  int         cyc = 0;
  int         ready_at = 0;
  bit         model_valid = 0;
  logic [7:0] log_d[$];
  int         log_c[$];

  always @(posedge clk) begin
    bit s_reset, s_clr, s_wr, s_thre, do_pop, full_pre;
    logic [7:0] s_din;
    int e;
    s_reset = reset; s_clr = bus.clr; s_wr = bus.wr; s_thre = bus.thre; s_din = bus.din;
    e = cyc;
    cyc++;
    if (s_reset) begin
      m_q.delete(); m_ovf = 0; m_core_wr = 0; m_core_d = 8'h00; ready_at = e + 1; model_valid = 1;
    end else if (s_clr) begin
      m_q.delete(); m_ovf = 0; m_core_wr = 0; ready_at = e + 1;
    end else begin
      do_pop   = (m_q.size() > 0) && s_thre && (e >= ready_at);
      full_pre = (m_q.size() == DEPTH_C);
      m_core_wr = do_pop;
      if (do_pop) begin
        m_core_d = m_q.pop_front();
        ready_at = e + 2 + GUARD_C;
      end
      if (s_wr) begin
        if (full_pre && !do_pop) m_ovf = 1;
        else m_q.push_back(s_din);
      end
    end
    #1;
    if (model_valid) begin
      chk("core_wr", int'(bus.core_wr), int'(m_core_wr));
      chk("core_d", int'(bus.core_d), int'(m_core_d));
      chk("level", int'(bus.level), m_q.size());
      chk("full", int'(bus.full), int'(m_q.size() == DEPTH_C));
      chk("empty", int'(bus.empty), int'(m_q.size() == 0));
      chk("ovf", int'(bus.ovf), int'(m_ovf));
      chk("irq_lw", int'(bus.irq_lw), int'(m_q.size() <= LOW_C));
    end
    if (bus.core_wr === 1'b1) begin
      log_d.push_back(bus.core_d);
      log_c.push_back(e);
      $display("[TB] edge %0d core write d=0x%02h level=%0d", e, bus.core_d, bus.level);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr = 1'b1;
    bus.din = b;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  initial begin
    int e0;
    int n;
    bus.wr = 1'b0; bus.din = 8'h00; bus.clr = 1'b0; bus.thre = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_irq", int'(bus.irq_lw), 1);
    chk("rst_core_wr", int'(bus.core_wr), 0);

    // Three bytes with thre held high: one push every 2+GUARD cycles.
    bus.thre = 1'b1;
    log_d.delete(); log_c.delete();
    e0 = cyc;
    write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
    repeat (20) tick();
    chk("t1_count", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("t1_b0", int'(log_d[0]), 'h41);
      chk("t1_b1", int'(log_d[1]), 'h42);
      chk("t1_b2", int'(log_d[2]), 'h43);
      chk("t1_latency", log_c[0] - e0, 1);
      chk("t1_gap0", log_c[1] - log_c[0], 4);
      chk("t1_gap1", log_c[2] - log_c[1], 4);
    end
    chk("t1_level", int'(bus.level), 0);
    chk("t1_empty", int'(bus.empty), 1);

    // Fill with thre low, overflow once, then drain.
    bus.thre = 1'b0;
    log_d.delete(); log_c.delete();
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    chk("t2_full", int'(bus.full), 1);
    chk("t2_level", int'(bus.level), 16);
    chk("t2_irq", int'(bus.irq_lw), 0);
    chk("t2_no_push", log_d.size(), 0);
    write_byte(8'hFF);
    chk("t2_ovf", int'(bus.ovf), 1);
    chk("t2_level_ovf", int'(bus.level), 16);
    bus.thre = 1'b1;
    repeat (80) tick();
    chk("t2_drain_count", log_d.size(), 16);
    if (log_d.size() == 16)
      for (int i = 0; i < 16; i++) chk("t2_drain_byte", int'(log_d[i]), i);

    // Full FIFO: write in the same edge as a pop.
    do_clr();
    bus.thre = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    log_d.delete(); log_c.delete();
    bus.thre = 1'b1;
    write_byte(8'hA5);
    chk("t3_level", int'(bus.level), 16);
    chk("t3_ovf", int'(bus.ovf), 0);
    repeat (80) tick();
    chk("t3_count", log_d.size(), 17);
    if (log_d.size() == 17) begin
      chk("t3_first", int'(log_d[0]), 'h10);
      chk("t3_last", int'(log_d[16]), 'hA5);
    end

    // Low watermark crossing.
    do_clr();
    bus.thre = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i));
    chk("t4_irq_low", int'(bus.irq_lw), 0);
    bus.thre = 1'b1;
    n = 0;
    while (bus.level != 5'd4 && n < 20) begin tick(); n++; end
    chk("t4_wait_level4", int'(bus.level), 4);
    chk("t4_irq_high", int'(bus.irq_lw), 1);

    // clr during a PUSH cycle at level 5 with ovf set; concurrent write is dropped.
    do_clr();
    bus.thre = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h80 + i));
    write_byte(8'hFF);
    chk("t5_ovf_set", int'(bus.ovf), 1);
    bus.thre = 1'b1;
    n = 0;
    while (!(bus.core_wr == 1'b1 && bus.level == 5'd5) && n < 100) begin tick(); n++; end
    chk("t5_wait_push_l5", int'(bus.level), 5);
    bus.clr = 1'b1; bus.wr = 1'b1; bus.din = 8'hEE;
    tick();
    bus.clr = 1'b0; bus.wr = 1'b0;
    chk("t5_level", int'(bus.level), 0);
    chk("t5_empty", int'(bus.empty), 1);
    chk("t5_ovf", int'(bus.ovf), 0);
    chk("t5_core_wr", int'(bus.core_wr), 0);
    log_d.delete(); log_c.delete();
    repeat (10) tick();
    chk("t5_no_push", log_d.size(), 0);

    // reset mid-drain at level 7.
    bus.thre = 1'b0;
    for (int i = 0; i < 10; i++) write_byte(8'(8'hC0 + i));
    bus.thre = 1'b1;
    n = 0;
    while (bus.level != 5'd7 && n < 60) begin tick(); n++; end
    chk("t6_wait_level7", int'(bus.level), 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_level", int'(bus.level), 0);
    chk("t6_empty", int'(bus.empty), 1);
    chk("t6_full", int'(bus.full), 0);
    chk("t6_ovf", int'(bus.ovf), 0);
    chk("t6_irq", int'(bus.irq_lw), 1);
    chk("t6_core_wr", int'(bus.core_wr), 0);
    chk("t6_core_d", int'(bus.core_d), 0);
    log_d.delete(); log_c.delete();
    repeat (12) tick();
    chk("t6_no_push", log_d.size(), 0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int blk = 0; blk < 15; blk++) begin
      int thre_pct;
      int wr_pct;
      thre_pct = int'($urandom_range(0, 100));
      wr_pct   = int'($urandom_range(10, 90));
      for (int c = 0; c < 200; c++) begin
        reset    = ($urandom_range(0, 299) == 0);
        bus.clr  = ($urandom_range(0, 79) == 0);
        bus.wr   = (int'($urandom_range(0, 99)) < wr_pct);
        bus.din  = 8'($urandom);
        bus.thre = (int'($urandom_range(0, 99)) < thre_pct);
        tick();
      end
    end
    reset = 1'b0; bus.clr = 1'b0; bus.wr = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
